// File: rtl/mul_seq_ctrl_pkg.sv
// mul_seq_ctrl_pkg: op and state encodings plus default width for the sequential multiplier
package mul_seq_ctrl_pkg;
    localparam int N_DEF = 32;
    typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU} op_t;
    typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, ITER, NEG_LO, NEG_HI, DONE} state_t;
endpackage

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: request/response bundle between the EX stage and the multiplier
interface mul_seq_ctrl_if
    import mul_seq_ctrl_pkg::*;
#(
    parameter int N = N_DEF
);
    logic start;
    logic kill;
    op_t op;
    logic [N-1:0] rs1;
    logic [N-1:0] rs2;
    logic busy;
    logic done;
    logic [N-1:0] result;
    modport master(output start, kill, op, rs1, rs2, input busy, done, result);
    modport slave(input start, kill, op, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/mul_seq_adder_mux.sv
// mul_seq_adder_mux: per-state operand select feeding the single shared N+1-bit ripple-carry adder
module mul_seq_adder_mux
    import mul_seq_ctrl_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  state_t       st,
    input  logic         n1,
    input  logic         n2,
    input  logic         ncarry,
    input  logic [N-1:0] r1,
    input  logic [N-1:0] r2,
    input  logic [N-1:0] mcand,
    input  logic [N-1:0] p_hi,
    input  logic [N-1:0] p_lo,
    output logic [N:0]   s
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N:0] c;
    always_comb begin
        a = st == PREP_A ? (n1 ? ~r1 : r1) :
            st == PREP_B ? (n2 ? ~r2 : r2) :
            st == ITER   ? p_hi :
            st == NEG_LO ? ~p_lo : ~p_hi;
        b = st == ITER ? mcand : '0;
        c[0] = st == PREP_A ? n1 :
               st == PREP_B ? n2 :
               st == NEG_LO ? 1'b1 :
               st == NEG_HI ? ncarry : 1'b0;
    end
    for (genvar i = 0; i < N; i++) begin : g_rca
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign s[N] = c[N];
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle shift-add multiplier (MUL/MULH/MULHSU/MULHU) on one shared adder.
// Define MUL_SEQ_EARLY_TERM_EN to finish ITER early once the remaining multiplier bits are zero.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = 6
) (
    input logic            clk,
    input logic            rst,
    mul_seq_ctrl_if.slave  bus
);
    state_t st;
    op_t opr;
    logic [N-1:0] r1, r2, mcand, result_q;
    logic [2*N-1:0] p;
    logic [CNT_W-1:0] cnt;
    logic n1, n2, neg, ncarry, busy_q, done_q;
    logic s1n, s2n;
    logic [N:0] s;
    logic [N-1:0] hi;
    assign s1n = (bus.op == OP_MULH || bus.op == OP_MULHSU) && bus.rs1[N-1];
    assign s2n = bus.op == OP_MULH && bus.rs2[N-1];
    assign hi  = neg ? s[N-1:0] : p[2*N-1:N];
`ifdef MUL_SEQ_EARLY_TERM_EN
    logic rem_zero;
    logic [CNT_W:0] shamt;
    // low N-cnt bits of P are the multiplier bits not yet consumed
    assign rem_zero = (p[N-1:0] & ({N{1'b1}} >> cnt)) == '0;
    assign shamt    = (CNT_W+1)'(N) - {1'b0, cnt};
`endif
    mul_seq_adder_mux #(.N(N)) u_add (
        .st(st), .n1(n1), .n2(n2), .ncarry(ncarry), .r1(r1), .r2(r2),
        .mcand(mcand), .p_hi(p[2*N-1:N]), .p_lo(p[N-1:0]), .s(s)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
            opr <= OP_MUL;
            r1 <= '0;
            r2 <= '0;
            mcand <= '0;
            p <= '0;
            cnt <= '0;
            n1 <= 1'b0;
            n2 <= 1'b0;
            neg <= 1'b0;
            ncarry <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            result_q <= '0;
        end else if (bus.kill) begin
            st <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (st)
                IDLE: if (bus.start) begin
                    opr <= bus.op;
                    r1 <= bus.rs1;
                    r2 <= bus.rs2;
                    n1 <= s1n;
                    n2 <= s2n;
                    neg <= s1n ^ s2n;
                    busy_q <= 1'b1;
                    st <= PREP_A;
                end
                PREP_A: begin
                    mcand <= s[N-1:0];
                    st <= PREP_B;
                end
                PREP_B: begin
                    p <= {{N{1'b0}}, s[N-1:0]};
                    cnt <= '0;
                    st <= ITER;
                end
                ITER:
`ifdef MUL_SEQ_EARLY_TERM_EN
                if (rem_zero) begin
                    p <= p >> shamt;
                    st <= NEG_LO;
                end else
`endif
                begin
                    p <= p[0] ? {s, p[N-1:1]} : {1'b0, p[2*N-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(N-1)) st <= NEG_LO;
                end
                NEG_LO: begin
                    if (neg) p[N-1:0] <= s[N-1:0];
                    ncarry <= s[N];
                    st <= NEG_HI;
                end
                NEG_HI: begin
                    p[2*N-1:N] <= hi;
                    result_q <= opr == OP_MUL ? p[N-1:0] : hi;
                    done_q <= 1'b1;
                    st <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    st <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule
